// File: rtl/fetch_pkg.sv
// Shared widths, default reset PC and the fetch buffer entry type for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// ROM, decode handshake and redirect signals of the fetch stage.
// master = fetch unit, slave = ROM/decode environment.
interface inst_fetch_unit_if;
  import fetch_pkg::*;

  logic              rom_ce_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [INST_W-1:0] rom_inst_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              id_valid_o;
  logic              id_ready_i;
  logic [ADDR_W-1:0] id_pc_o;
  logic [INST_W-1:0] id_inst_o;
  logic              addr_err_o;

  modport master (
    output rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, addr_err_o,
    input  rom_inst_i, redirect_i, redirect_pc_i, id_ready_i
  );

  modport slave (
    input  rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, addr_err_o,
    output rom_inst_i, redirect_i, redirect_pc_i, id_ready_i
  );

endinterface

// File: rtl/fetch_skid_fifo.sv
// Depth-parameterised FIFO of fetch entries; clear wins over push/pop, and a push is
// accepted when full as long as the head is popped in the same cycle.
module fetch_skid_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  input  fetch_entry_t               wdata_i,
  output fetch_entry_t               rdata_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  fetch_entry_t    mem_q [Depth];
  logic            do_push, do_pop;

  assign do_pop  = pop_i & (count_q != '0);
  assign do_push = push_i & ((count_q != CntW'(Depth)) | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop) begin
        rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      if (do_push) begin
        wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      // When full, wr_ptr == rd_ptr: the slot being popped is the one overwritten.
      if (do_push && !clear_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
      end
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: PC, ROM enable sequencing, redirect handling and decode handshake.
// Optional misaligned-redirect trap enabled by defining FETCH_ALIGN_CHECK_EN.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned       BUF_DEPTH = 2
) (
  input logic               clk,
  input logic               rst_n,
  inst_fetch_unit_if.master bus
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

  logic              ce_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] target_pc;
  logic [CntW-1:0]   count;
  logic              id_valid, pop, push, fetch_blocked;
  fetch_entry_t      wdata, head;

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_q, err_d;

  assign target_pc     = bus.redirect_pc_i;
  assign fetch_blocked = err_q;

  // Sticky until a later aligned redirect.
  always_comb begin
    err_d = err_q;
    if (bus.redirect_i) begin
      err_d = |bus.redirect_pc_i[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.addr_err_o = err_q;
`else
  assign target_pc      = {bus.redirect_pc_i[ADDR_W-1:2], 2'b00};
  assign fetch_blocked  = 1'b0;
  assign bus.addr_err_o = 1'b0;
`endif

  assign id_valid = (count != '0);
  assign pop      = id_valid & bus.id_ready_i;
  assign push     = ce_q & ~bus.redirect_i & ~fetch_blocked
                  & ((count != CntW'(BUF_DEPTH)) | pop);

  always_comb begin
    pc_d = pc_q;
    if (bus.redirect_i) begin
      pc_d = target_pc;
    end else if (push) begin
      pc_d = pc_q + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_q <= 1'b0;
      pc_q <= RESET_PC;
    end else begin
      ce_q <= 1'b1;
      pc_q <= pc_d;
    end
  end

  assign wdata.pc   = pc_q;
  assign wdata.inst = bus.rom_inst_i;

  fetch_skid_fifo #(
    .Depth (BUF_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (bus.redirect_i),
    .wdata_i (wdata),
    .rdata_o (head),
    .count_o (count)
  );

  assign bus.rom_ce_o   = ce_q;
  assign bus.rom_addr_o = pc_q;
  assign bus.id_valid_o = id_valid;
  assign bus.id_pc_o    = head.pc;
  assign bus.id_inst_o  = head.inst;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit (BUF_DEPTH = 2) with a combinational ROM model.
module tb_inst_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  inst_fetch_unit_if bus ();

  inst_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    case (addr)
      32'h0:   rom_word = 32'h3408_0001;
      32'h4:   rom_word = 32'h3409_0001;
      32'h8:   rom_word = 32'h0109_5021;
      default: rom_word = 32'hEE00_0000 ^ addr;
    endcase
  endfunction

  always_comb bus.rom_inst_i = rom_word(bus.rom_addr_o);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(bus.id_valid_o), 32'd1);
    check({tag, "_pc"}, bus.id_pc_o, pc);
    check({tag, "_inst"}, bus.id_inst_o, rom_word(pc));
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.id_ready_i    = 1'b0;
    repeat (3) step();
    check("rst_ce", 32'(bus.rom_ce_o), 32'd0);
    check("rst_addr", bus.rom_addr_o, 32'h0);
    check("rst_valid", 32'(bus.id_valid_o), 32'd0);
    check("rst_pc", bus.id_pc_o, 32'h0);
    check("rst_inst", bus.id_inst_o, 32'h0);
    check("rst_err", 32'(bus.addr_err_o), 32'd0);

    // Release: ce on first edge, first valid after the second.
    rst_n = 1'b1;
    step();
    check("ce_up", 32'(bus.rom_ce_o), 32'd1);
    check("ce_addr", bus.rom_addr_o, 32'h0);
    check("ce_novalid", 32'(bus.id_valid_o), 32'd0);
    step();
    check("first_valid", 32'(bus.id_valid_o), 32'd1);
    check("first_pc", bus.id_pc_o, 32'h0);
    check("first_inst", bus.id_inst_o, 32'h3408_0001);
    check("first_addr", bus.rom_addr_o, 32'h4);

    // Straight-line streaming
    bus.id_ready_i = 1'b1;
    step();
    check("s4_inst", bus.id_inst_o, 32'h3409_0001);
    check("s4_pc", bus.id_pc_o, 32'h4);
    step();
    check("s8_inst", bus.id_inst_o, 32'h0109_5021);
    check("s8_pc", bus.id_pc_o, 32'h8);
    step();
    expect_head("s12", 32'hC);

    // Backpressure: buffer holds {12,16}, PC frozen at 20
    bus.id_ready_i = 1'b0;
    repeat (5) step();
    expect_head("bp_hold", 32'hC);
    check("bp_addr", bus.rom_addr_o, 32'h14);
    bus.id_ready_i = 1'b1;
    step();
    expect_head("bp_d16", 32'h10);
    step();
    expect_head("bp_d20", 32'h14);
    step();
    expect_head("bp_d24", 32'h18);
    check("bp_addr2", bus.rom_addr_o, 32'h20);

    // Redirect with two buffered entries
    bus.id_ready_i    = 1'b0;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h40;
    step();
    check("rd_novalid", 32'(bus.id_valid_o), 32'd0);
    check("rd_addr", bus.rom_addr_o, 32'h40);
    bus.redirect_i = 1'b0;
    bus.id_ready_i = 1'b1;
    step();
    expect_head("rd_40", 32'h40);
    step();
    expect_head("rd_44", 32'h44);

    // Redirect coinciding with pop on a full buffer
    bus.id_ready_i = 1'b0;
    step();
    expect_head("rp_full", 32'h44);
    bus.id_ready_i    = 1'b1;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h100;
    step();
    check("rp_novalid", 32'(bus.id_valid_o), 32'd0);
    check("rp_addr", bus.rom_addr_o, 32'h100);
    bus.redirect_i = 1'b0;
    step();
    expect_head("rp_100", 32'h100);
    step();
    expect_head("rp_104", 32'h104);

    // Misaligned redirect
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h42;
    step();
    check("mis_novalid", 32'(bus.id_valid_o), 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    check("mis_err", 32'(bus.addr_err_o), 32'd1);
    check("mis_addr", bus.rom_addr_o, 32'h42);
    bus.redirect_i = 1'b0;
    repeat (2) step();
    check("mis_stall_valid", 32'(bus.id_valid_o), 32'd0);
    check("mis_stall_err", 32'(bus.addr_err_o), 32'd1);
    check("mis_stall_addr", bus.rom_addr_o, 32'h42);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h80;
    step();
    check("mis_clr_err", 32'(bus.addr_err_o), 32'd0);
    check("mis_clr_addr", bus.rom_addr_o, 32'h80);
    bus.redirect_i = 1'b0;
    step();
    expect_head("mis_80", 32'h80);
`else
    check("mis_err", 32'(bus.addr_err_o), 32'd0);
    check("mis_addr", bus.rom_addr_o, 32'h40);
    bus.redirect_i = 1'b0;
    step();
    expect_head("mis_40", 32'h40);
    step();
    expect_head("mis_44", 32'h44);
`endif

    // PC wrap at the top of the address space
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFFC;
    step();
    bus.redirect_i = 1'b0;
    step();
    expect_head("wrap_top", 32'hFFFF_FFFC);
    check("wrap_addr", bus.rom_addr_o, 32'h0);
    step();
    expect_head("wrap_zero", 32'h0);

    // Asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(bus.id_valid_o), 32'd0);
    check("ar_ce", 32'(bus.rom_ce_o), 32'd0);
    check("ar_addr", bus.rom_addr_o, 32'h0);
    check("ar_pc", bus.id_pc_o, 32'h0);
    check("ar_inst", bus.id_inst_o, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
